// File: rtl/translation_lookaside_buffer_pkg.sv
// Shared TLB types: page and entry layouts, INVTLB op codes and field widths.
package tlb_pkg;

  localparam int PPN_W      = 20;
  localparam int VPPN_W     = 19;
  localparam int TLB_ASID_W = 10;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       plv;
    logic [1:0]       mat;
    logic             d;
    logic             v;
  } tlb_page_t;

  typedef struct packed {
    logic [VPPN_W-1:0]     vppn;
    logic                  ps4m;
    logic                  g;
    logic [TLB_ASID_W-1:0] asid;
    logic                  e;
    tlb_page_t             page0;
    tlb_page_t             page1;
  } tlb_entry_t;

  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GVA        = 5'd6;

endpackage

// File: rtl/translation_lookaside_buffer_match.sv
// Per-entry tag compare: VA match (page-size aware) and ASID equality vectors.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 16
) (
  input  logic [TLB_ENTRIES-1:0][VPPN_W-1:0]     vppn_i,
  input  logic [TLB_ENTRIES-1:0]                 ps4m_i,
  input  logic [TLB_ENTRIES-1:0][TLB_ASID_W-1:0] asid_i,
  input  logic [VPPN_W-1:0]                      key_vppn_i,
  input  logic [TLB_ASID_W-1:0]                  key_asid_i,
  output logic [TLB_ENTRIES-1:0]                 va_hit_o,
  output logic [TLB_ENTRIES-1:0]                 asid_hit_o
);

  always_comb begin
    va_hit_o   = '0;
    asid_hit_o = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      // 4 MB pages only compare the upper ten VPPN bits
      va_hit_o[i]   = ps4m_i[i] ? (vppn_i[i][VPPN_W-1:9] == key_vppn_i[VPPN_W-1:9])
                                : (vppn_i[i] == key_vppn_i);
      asid_hit_o[i] = (asid_i[i] == key_asid_i);
    end
  end

endmodule

// File: rtl/translation_lookaside_buffer.sv
// Fully-associative TLB: registered single-port lookup, entry write/read and INVTLB.
module translation_lookaside_buffer
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_W      = TLB_ASID_W,
  localparam int IDX_W      = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [31:0]       s_vaddr,
  input  logic [ASID_W-1:0] s_asid,
  input  logic              stall,
  output logic              r_valid,
  output logic              r_found,
  output logic [IDX_W-1:0]  r_index,
  output tlb_page_t         r_page,
  output logic              r_ps4m,
  input  logic              w_en,
  input  logic [IDX_W-1:0]  w_index,
  input  tlb_entry_t        w_entry,
  input  logic [IDX_W-1:0]  rd_index,
  output tlb_entry_t        rd_entry,
  input  logic              inv_en,
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [31:0]       inv_vaddr,
  output logic              inv_illegal
);

  tlb_entry_t [TLB_ENTRIES-1:0] entries_q, entries_d;
  tlb_entry_t                   rd_entry_q;

  logic             r_valid_q, r_found_q, r_ps4m_q;
  logic [IDX_W-1:0] r_index_q;
  tlb_page_t        r_page_q;

  logic [TLB_ENTRIES-1:0][VPPN_W-1:0]     tag_vppn;
  logic [TLB_ENTRIES-1:0][TLB_ASID_W-1:0] tag_asid;
  logic [TLB_ENTRIES-1:0]                 tag_ps4m, tag_g, tag_e;

  always_comb begin
    tag_vppn = '0;
    tag_asid = '0;
    tag_ps4m = '0;
    tag_g    = '0;
    tag_e    = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      tag_vppn[i] = entries_q[i].vppn;
      tag_asid[i] = entries_q[i].asid;
      tag_ps4m[i] = entries_q[i].ps4m;
      tag_g[i]    = entries_q[i].g;
      tag_e[i]    = entries_q[i].e;
    end
  end

  logic [TLB_ENTRIES-1:0] lk_va_hit, lk_asid_hit, lk_hit;
  logic [TLB_ENTRIES-1:0] inv_va_hit, inv_asid_hit, inv_clr;

  tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_lookup_match (
    .vppn_i    (tag_vppn),
    .ps4m_i    (tag_ps4m),
    .asid_i    (tag_asid),
    .key_vppn_i(s_vaddr[31:13]),
    .key_asid_i(s_asid),
    .va_hit_o  (lk_va_hit),
    .asid_hit_o(lk_asid_hit)
  );

  tlb_match #(.TLB_ENTRIES(TLB_ENTRIES)) u_inv_match (
    .vppn_i    (tag_vppn),
    .ps4m_i    (tag_ps4m),
    .asid_i    (tag_asid),
    .key_vppn_i(inv_vaddr[31:13]),
    .key_asid_i(inv_asid),
    .va_hit_o  (inv_va_hit),
    .asid_hit_o(inv_asid_hit)
  );

  assign lk_hit = tag_e & (tag_g | lk_asid_hit) & lk_va_hit;

  // Lowest index wins when several entries overlap
  logic             lk_any;
  logic [IDX_W-1:0] hit_idx;
  always_comb begin
    lk_any  = 1'b0;
    hit_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (lk_hit[i]) begin
        lk_any  = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  tlb_entry_t hit_entry;
  logic       hit_odd;
  tlb_page_t  hit_page;
  assign hit_entry = entries_q[hit_idx];
  assign hit_odd   = hit_entry.ps4m ? s_vaddr[21] : s_vaddr[12];
  assign hit_page  = hit_odd ? hit_entry.page1 : hit_entry.page0;

  assign inv_illegal = inv_en && (inv_op > INV_GVA);

  always_comb begin
    inv_clr = '0;
    if (inv_en) begin
      case (inv_op)
        INV_ALL0, INV_ALL1: inv_clr = '1;
        INV_G:              inv_clr = tag_g;
        INV_NG:             inv_clr = ~tag_g;
        INV_NG_ASID:        inv_clr = ~tag_g & inv_asid_hit;
        INV_NG_ASID_VA:     inv_clr = ~tag_g & inv_asid_hit & inv_va_hit;
        INV_GVA:            inv_clr = (tag_g | inv_asid_hit) & inv_va_hit;
        default:            inv_clr = '0;
      endcase
    end
  end

  // Invalidate first so a same-cycle write always lands intact
  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (inv_clr[i]) entries_d[i].e = 1'b0;
    end
    if (w_en) entries_d[w_index] = w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q  <= '0;
      rd_entry_q <= '0;
      r_valid_q  <= 1'b0;
      r_found_q  <= 1'b0;
      r_index_q  <= '0;
      r_page_q   <= '0;
      r_ps4m_q   <= 1'b0;
    end else begin
      entries_q  <= entries_d;
      rd_entry_q <= entries_q[rd_index];
      if (!stall) begin
        r_valid_q <= s_valid;
        r_found_q <= s_valid && lk_any;
        r_index_q <= (s_valid && lk_any) ? hit_idx : '0;
        r_page_q  <= (s_valid && lk_any) ? hit_page : '0;
        r_ps4m_q  <= s_valid && lk_any && hit_entry.ps4m;
      end
    end
  end

  logic unused_vaddr_bits;
  assign unused_vaddr_bits = ^{s_vaddr[11:0], inv_vaddr[12:0]};

  assign r_valid  = r_valid_q;
  assign r_found  = r_found_q;
  assign r_index  = r_index_q;
  assign r_page   = r_page_q;
  assign r_ps4m   = r_ps4m_q;
  assign rd_entry = rd_entry_q;

endmodule

// File: doc/translation_lookaside_buffer.md
Name: translation_lookaside_buffer

Overview:
Fully-associative, LoongArch32-style TLB array. It sits directly upstream of MemoryManagementUnit and feeds it registered lookup results for one translation port. It also services the CSR-side TLBWR/TLBFILL, TLBRD and INVTLB operations. Lookup uses a 1-cycle compare-and-register pipeline with a stall hold; entries live in flops.

Parameters:
TLB_ENTRIES, 16, number of entries; power of 2, 4..64
IDX_W, $clog2(TLB_ENTRIES), index width (derived localparam)
ASID_W, 10, ASID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
s_valid  in  1  lookup request this cycle
s_vaddr  in  32  lookup virtual address
s_asid  in  ASID_W  current ASID
stall  in  1  hold response registers (MMU back-pressure)
r_valid  out  1  response valid
r_found  out  1  hit
r_index  out  IDX_W  hit index
r_page  out  tlb_page_t  selected even/odd page {ppn[19:0], plv[1:0], mat[1:0], d, v}
r_ps4m  out  1  hit page is 4 MB (else 4 KB)
w_en  in  1  write entry
w_index  in  IDX_W  write index
w_entry  in  tlb_entry_t  entry to write
rd_index  in  IDX_W  read index
rd_entry  out  tlb_entry_t  registered read data
inv_en  in  1  INVTLB request
inv_op  in  5  INVTLB op
inv_asid  in  ASID_W  INVTLB asid operand
inv_vaddr  in  32  INVTLB va operand
inv_illegal  out  1  combinational: inv_en with inv_op>6

Behaviour:
- Clock clk, reset rst_n: asynchronous, active low. Reset clears every entry's E bit, r_valid, r_found, r_index, r_page, r_ps4m and rd_entry to 0. Other entry fields are don't-care.
- Entry fields: vppn[18:0], ps4m, g, asid, e, page0, page1.
- Match for entry i: e & (g | asid==s_asid) & (ps4m ? vppn[18:9]==s_vaddr[31:22] : vppn==s_vaddr[31:13]).
- Odd-page select: ps4m ? s_vaddr[21] : s_vaddr[12].
- Multiple hits: the lowest index wins (priority encoder). This is deterministic, not an error.
- Lookup latency is 1 cycle. When stall=0, at the clock edge: r_valid<=s_valid; r_found/r_index/r_page/r_ps4m<=compare result. When s_valid=0 or there is a miss, r_found=0 and r_page/r_index/r_ps4m=0.
- When stall=1, all r_* hold their values and s_* is ignored. The requester keeps s_valid/s_vaddr asserted until stall drops.
- Read: rd_entry<=entry[rd_index] every cycle (1-cycle latency). It shows pre-write contents on a same-cycle write.
- Write: entry[w_index]<=w_entry at the edge. A lookup in the same cycle compares against the old contents.
- INVTLB clears E of every matching entry in one cycle. va match uses the same ps4m-dependent vppn compare as lookup, against inv_vaddr.
  - op 0/1: all entries
  - op 2: g=1
  - op 3: g=0
  - op 4: g=0 & asid==inv_asid
  - op 5: g=0 & asid==inv_asid & va match
  - op 6: (g=1 | asid==inv_asid) & va match
  - op 7..31: no change; inv_illegal=1 while inv_en.
- Write and invalidate in the same cycle: invalidate applies first, then the write. Entry w_index ends equal to w_entry.
- Lookup and invalidate in the same cycle: the lookup compares against pre-invalidate contents.
- Reset mid-operation: all in-flight responses are discarded; r_valid=0 after reset deasserts.

Decomposition:
- Shared package tlb_pkg, placed in TranslationLookasideBuffer.svh, holds:
  - tlb_page_t and tlb_entry_t packed structs
  - INVTLB op localparams INV_ALL0..INV_GVA
  - PPN_W=20, VPPN_W=19
- One sub-module, tlb_match: combinational per-entry compare producing a TLB_ENTRIES-wide hit vector. It is instantiated twice, once for lookup and once for invalidate va/asid matching.
- The priority encoder and page mux stay in the top module.

Test Plan:
- Reset, then s_valid=1, va=0x0040_1000 -> next cycle r_valid=1, r_found=0.
- Write idx3 {vppn=0x00200, ps4m=0, g=0, asid=5, e=1, page1.ppn=0x12345, v=1}. Then lookup va=0x0040_1000, asid=5 -> r_found=1, r_index=3, r_page.ppn=0x12345 (odd page). Same lookup with asid=6 -> r_found=0.
- 4 MB entry idx0 {vppn=0x00400, ps4m=1, g=1} plus a duplicate 4 KB entry idx7 covering va 0x0080_3000 -> r_index=0. Va 0x00A0_0000 selects page1.
- Stall held 3 cycles while s_vaddr changes -> r_* unchanged. First cycle after release reflects the current s_vaddr.
- INVTLB op=4, asid=5 with mixed g=0/g=1 entries -> only g=0, asid=5 entries lose E. op=9 -> inv_illegal=1, no entry changed.
- Same-cycle w_en idx3 plus inv op=0 -> only idx3 valid afterwards. Same-cycle lookup of idx3's va hits the old contents.
